mem_port_arbiter: RTL

- Shares the single-port unified instruction/data memory between the fetch stage and the load/store path.
- Arbitrates between the two requesters and drives the memory port.
- Tracks the one outstanding read and routes its returned data to the correct requester.
- Sits between the PC/fetch logic, the LSU, and the memory macro. The core stalls on missing grants.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by fetch and load/store; tracks one outstanding read.
// Defining MEM_ARB_PERF_CNT_EN adds saturating per-requester stall counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_bmask,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         o_if_stall_cnt,
  output logic [31:0]         o_ls_stall_cnt
`endif
);

  typedef enum logic {ST_IDLE, ST_RD_WAIT} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        resp, window, starved, gnt_if, gnt_ls, rd_gnt;

  always_comb begin
    resp    = (state_q == ST_RD_WAIT) && (cnt_q == 2'd0);
    window  = (state_q == ST_IDLE) || resp;
    starved = (starve_q == 4'(STARVE_MAX));
    // Grants are combinational from the request lines, so they must be held low while in reset.
    gnt_ls  = i_reset && window && i_ls_req && !(i_if_req && starved);
    gnt_if  = i_reset && window && i_if_req && !gnt_ls;
    rd_gnt  = gnt_if || (gnt_ls && !i_ls_we);
  end

  always_comb begin
    o_if_gnt    = gnt_if;
    o_ls_gnt    = gnt_ls;
    o_mem_req   = gnt_if || gnt_ls;
    o_mem_we    = gnt_ls && i_ls_we;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    if (gnt_ls) begin
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_bmask = i_ls_bmask;
    end else if (gnt_if) begin
      o_mem_addr  = i_if_addr;
      o_mem_bmask = '1;
    end
    o_if_rvalid = resp && !owner_q;
    o_ls_rvalid = resp && owner_q;
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
    o_busy      = (state_q == ST_RD_WAIT);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    if (rd_gnt) begin
      state_d = ST_RD_WAIT;
      cnt_d   = 2'(RD_LAT - 1);
      owner_d = gnt_ls;
    end else if ((state_q == ST_RD_WAIT) && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end else begin
      state_d = ST_IDLE;
    end
    if (!i_if_req || gnt_if) begin
      starve_d = 4'd0;
    end else if (gnt_ls && !starved) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= 2'd0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] if_stall_q, if_stall_d, ls_stall_q, ls_stall_d;

  always_comb begin
    if_stall_d = if_stall_q;
    ls_stall_d = ls_stall_q;
    if (i_if_req && !gnt_if && (if_stall_q != 32'hFFFF_FFFF)) if_stall_d = if_stall_q + 32'd1;
    if (i_ls_req && !gnt_ls && (ls_stall_q != 32'hFFFF_FFFF)) ls_stall_d = ls_stall_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      if_stall_q <= 32'd0;
      ls_stall_q <= 32'd0;
    end else begin
      if_stall_q <= if_stall_d;
      ls_stall_q <= ls_stall_d;
    end
  end

  assign o_if_stall_cnt = if_stall_q;
  assign o_ls_stall_cnt = ls_stall_q;
`endif

endmodule
